// File: rtl/cb_cfg_pkg.sv
// Shared definitions for the parametrised connection block.
// Purpose : compile-time helpers that size the configuration chain and
//           compute which channel track each pin-mux input taps.
// Contents: clog2, sel_w, chain_len, tap_track.
package cb_cfg_pkg;

    // Ceiling log2 that also works in constant contexts.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Select field width for a 2*fc input mux; a one-input mux still needs a bit.
    function automatic int sel_w(input int fc);
        int w;
        w = clog2(2 * fc);
        return (w < 1) ? 1 : w;
    endfunction

    // Total scan chain length: one select field per pin.
    function automatic int chain_len(input int num_pins, input int fc);
        return num_pins * sel_w(fc);
    endfunction

    // Track tapped by tap k of pin p, wrapping around the channel width.
    function automatic int tap_track(input int p, input int k,
                                     input int stride, input int chan_w);
        return (p + k * stride) % chan_w;
    endfunction

endpackage

// File: rtl/cb_cfg_chain.sv
// Configuration storage for the connection block.
// Purpose : shadow scan register loaded from ccff_head, a bit counter that
//           says when the shadow is full, and a commit handshake that copies
//           the shadow into the active register used by the pin muxes.
// Ports   : prog_clk / pReset (sync, active-high)
//           ccff_head, cfg_en, cfg_commit      - scan data, shift, commit
//           ccff_tail                          - last shadow bit
//           cfg_done, cfg_active_valid, cfg_err- status
//           active                             - committed configuration
module cb_cfg_chain
    import cb_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 24
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 ccff_head,
    input  logic                 cfg_en,
    input  logic                 cfg_commit,
    output logic                 ccff_tail,
    output logic                 cfg_done,
    output logic                 cfg_active_valid,
    output logic                 cfg_err,
    output logic [CHAIN_LEN-1:0] active
);

    localparam int CNT_W = clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] sr;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 commit_ok;

    // A commit is honoured only on a full shadow with no shift in flight,
    // so the active word can never be a mix of old and new bits.
    assign commit_ok = cfg_commit && cfg_done && !cfg_en;

    // Counter saturates so over-shifting for chaining keeps cfg_done high.
    always_comb begin
        bit_cnt_next = bit_cnt;
        if (commit_ok) begin
            bit_cnt_next = '0;
        end else if (cfg_en && (bit_cnt != FULL)) begin
            bit_cnt_next = bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr               <= '0;
            active           <= '0;
            bit_cnt          <= '0;
            cfg_done         <= 1'b0;
            cfg_active_valid <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            if (cfg_en) begin
                sr <= {sr[CHAIN_LEN-2:0], ccff_head};
            end
            if (commit_ok) begin
                active           <= sr;
                cfg_active_valid <= 1'b1;
            end else if (cfg_commit) begin
                cfg_err <= 1'b1;
            end
            bit_cnt  <= bit_cnt_next;
            cfg_done <= (bit_cnt_next == FULL);
        end
    end

    assign ccff_tail = sr[CHAIN_LEN-1];

endmodule

// File: rtl/cbx_param_cfg.sv
// Parametrised horizontal connection block.
// Purpose : passes the channel straight through in both directions and
//           drives NUM_PINS grid input pins, each from a 2*FC input mux
//           tapping both channel sides, selected by a committed config word.
// Ports   : prog_clk / pReset (sync, active-high)
//           chanx_left_in/right_in   - channel tracks in
//           chanx_left_out/right_out - channel passthrough
//           ipin_out                 - grid pin drives
//           ccff_head/ccff_tail      - scan chain in/out
//           cfg_en, cfg_commit       - shift enable, commit request
//           cfg_done, cfg_active_valid, cfg_err - status
module cbx_param_cfg
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W   = 8,
    parameter int NUM_PINS = 12,
    parameter int FC       = 2,
    parameter int STRIDE   = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_PINS-1:0] ipin_out,
    input  logic                ccff_head,
    input  logic                cfg_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic                cfg_done,
    output logic                cfg_active_valid,
    output logic                cfg_err
);

    localparam int MUX_SIZE  = 2 * FC;
    localparam int SEL_W     = sel_w(FC);
    localparam int CHAIN_LEN = chain_len(NUM_PINS, FC);

    logic [CHAIN_LEN-1:0] active;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    cb_cfg_chain #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_chain (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .ccff_head       (ccff_head),
        .cfg_en          (cfg_en),
        .cfg_commit      (cfg_commit),
        .ccff_tail       (ccff_tail),
        .cfg_done        (cfg_done),
        .cfg_active_valid(cfg_active_valid),
        .cfg_err         (cfg_err),
        .active          (active)
    );

    // Even mux inputs come from the left side, odd from the right; select
    // codes beyond the mux size leave the pin disconnected (driven low).
    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [MUX_SIZE-1:0] cand;
        logic [SEL_W-1:0]    sel;

        assign sel = active[p*SEL_W +: SEL_W];

        for (genvar k = 0; k < FC; k++) begin : g_tap
            assign cand[2*k]   = chanx_left_in[tap_track(p, k, STRIDE, CHAN_W)];
            assign cand[2*k+1] = chanx_right_in[tap_track(p, k, STRIDE, CHAN_W)];
        end

        assign ipin_out[p] = cfg_active_valid && (int'(sel) < MUX_SIZE) && cand[sel];
    end

endmodule
